// File: rtl/relay_req_if.sv
// Request channel of the relay break-before-make sequencer: a valid/ready
// handshake carrying the target channel select (0 = all open).
interface relay_req_if #(
   parameter int SEL_W = 3
) ();
   logic             req_valid;
   logic             req_ready;
   logic [SEL_W-1:0] req_sel;

   modport master (output req_valid, output req_sel, input  req_ready);
   modport slave  (input  req_valid, input  req_sel, output req_ready);
endinterface

// File: rtl/relay_break_make_seq.sv
// Break-before-make relay coil sequencer: opens all coils, waits BREAK_CYCLES,
// closes the requested coil, waits SETTLE_CYCLES, then pulses done.
// Optional feature macro: RELAY_SEQ_HOLD_PWM_EN (PWM hold drive after settle).
module relay_break_make_seq #(
   parameter int N_CH          = 4,
   parameter int SEL_W         = 3,
   parameter int BREAK_CYCLES  = 16,
   parameter int SETTLE_CYCLES = 64,
`ifdef RELAY_SEQ_HOLD_PWM_EN
   parameter int HOLD_DUTY     = 8,
`endif
   parameter int CNT_W         = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   relay_req_if.slave        req,
   input  logic              open_all,
   output logic [N_CH-1:0]   coil,
   output logic [SEL_W-1:0]  active_sel,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, BREAK, MAKE, DONE} state_t;

   localparam logic [CNT_W-1:0] BREAK_LOAD  = CNT_W'(BREAK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [SEL_W-1:0] MAX_SEL     = SEL_W'(N_CH);

   state_t            state_q, state_d;
   logic [SEL_W-1:0]  tgt_q, tgt_d;
   logic [CNT_W-1:0]  timer_q, timer_d;
   logic [N_CH-1:0]   coil_q, coil_d;
   logic [SEL_W-1:0]  active_q, active_d;
   logic              err_q, err_d;
   logic [N_CH-1:0]   tgt_onehot;

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         tgt_onehot[i] = (tgt_q == SEL_W'(i + 1));
      end
   end

   always_comb begin
      // NOTE: every next-value signal gets its hold value first so no branch can infer a latch.
      state_d  = state_q;
      tgt_d    = tgt_q;
      timer_d  = timer_q;
      coil_d   = coil_q;
      active_d = active_q;
      err_d    = err_q;

      unique case (state_q)
         IDLE: begin
            if (req.req_valid) begin
               tgt_d = req.req_sel;
               if (req.req_sel > MAX_SEL) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else if (req.req_sel == active_q) begin
                  state_d = DONE;
               end else begin
                  coil_d   = '0;
                  active_d = '0;
                  timer_d  = BREAK_LOAD;
                  state_d  = BREAK;
               end
            end
         end
         BREAK: begin
            if (timer_q == '0) begin
               if (tgt_q == '0) begin
                  state_d = DONE;
               end else begin
                  coil_d  = tgt_onehot;
                  timer_d = SETTLE_LOAD;
                  state_d = MAKE;
               end
            end else begin
               timer_d = timer_q - CNT_W'(1);
            end
         end
         MAKE: begin
            if (timer_q == '0) begin
               active_d = tgt_q;
               state_d  = DONE;
            end else begin
               timer_d = timer_q - CNT_W'(1);
            end
         end
         DONE: begin
            err_d   = 1'b0;
            state_d = IDLE;
         end
      endcase

      // Emergency open wins over any sequence step, including a pending done.
      if (open_all) begin
         state_d  = IDLE;
         timer_d  = '0;
         coil_d   = '0;
         active_d = '0;
         err_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         tgt_q    <= '0;
         timer_q  <= '0;
         coil_q   <= '0;
         active_q <= '0;
         err_q    <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
         state_q  <= state_d;
         tgt_q    <= tgt_d;
         timer_q  <= timer_d;
         coil_q   <= coil_d;
         active_q <= active_d;
         err_q    <= err_d;
      end
   end

   assign req.req_ready = (state_q == IDLE) && !open_all;
   assign busy          = (state_q != IDLE);
   assign done          = (state_q == DONE) && !open_all;
   assign err           = done && err_q;
   assign active_sel    = active_q;

`ifdef RELAY_SEQ_HOLD_PWM_EN
   logic       hold_q;
   logic [3:0] hold_cnt_q;
   logic       enter_hold;
   logic       pwm_on;

   assign enter_hold = (state_q == MAKE) && (state_d == DONE);
   assign pwm_on     = int'(hold_cnt_q) < HOLD_DUTY;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q     <= 1'b0;
         hold_cnt_q <= '0;
      end else begin
         hold_q     <= enter_hold || (hold_q && (coil_d != '0));
         hold_cnt_q <= enter_hold ? 4'd0 : hold_cnt_q + 4'd1;
      end
   end

   // Full drive during MAKE; duty-cycled only once the contact has settled.
   assign coil = (hold_q && !pwm_on) ? '0 : coil_q;
`else
   assign coil = coil_q;
`endif

endmodule

// File: tb/tb_relay_break_make_seq.sv
// Randomized self-checking bench for relay_break_make_seq, compared each cycle
// against a transaction-timing reference model derived from the sequence rules.
module tb_relay_break_make_seq;
   localparam int N_CH  = 4;
   localparam int SEL_W = 3;
   localparam int B     = 16;
   localparam int S     = 64;
   localparam int CNT_W = 8;
   localparam int HOLD  = 8;

   localparam int K_SHORT  = 0;
   localparam int K_OPEN   = 1;
   localparam int K_CHANGE = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             open_all = 1'b0;
   logic [N_CH-1:0]  coil;
   logic [SEL_W-1:0] active_sel;
   logic             busy, done, err;

   relay_req_if #(.SEL_W(SEL_W)) rq ();

   relay_break_make_seq #(
      .N_CH(N_CH), .SEL_W(SEL_W), .BREAK_CYCLES(B),
      .SETTLE_CYCLES(S), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(rq.slave), .open_all(open_all),
      .coil(coil), .active_sel(active_sel), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: one transaction at a time, tracked by cycles since accept.
   bit m_seq;
   int m_k, m_kdone, m_kind, m_tgt;
   bit m_inv;
   int m_active, m_coil, hold_age;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   function automatic int onehot(input int ch);
      return (ch == 0) ? 0 : (1 << (ch - 1));
   endfunction

   task automatic model_reset();
      m_seq = 0; m_k = 0; m_kdone = 0; m_kind = K_SHORT; m_tgt = 0;
      m_inv = 0; m_active = 0; m_coil = 0; hold_age = 0;
   endtask

   task automatic model_step(input bit v, input int sel, input bit oa);
      hold_age++;
      if (oa) begin
         m_seq = 0; m_active = 0; m_coil = 0;
      end else if (m_seq) begin
         if (m_k == m_kdone) begin
            m_seq = 0;
            if (m_kind == K_CHANGE) begin m_active = m_tgt; m_coil = m_tgt; end
            else if (m_kind == K_OPEN) begin m_active = 0; m_coil = 0; end
         end else begin
            m_k++;
            if (m_kind == K_CHANGE && m_k == m_kdone) hold_age = 0;
         end
      end else if (v) begin
         m_seq = 1; m_k = 1; m_tgt = sel; m_inv = (sel > N_CH);
         if (m_inv || sel == m_active) begin m_kind = K_SHORT;  m_kdone = 1;         end
         else if (sel == 0)            begin m_kind = K_OPEN;   m_kdone = B + 1;     end
         else                          begin m_kind = K_CHANGE; m_kdone = B + S + 1; end
      end
   endtask

   task automatic compare(input bit oa);
      int e_ready, e_busy, e_done, e_err, e_active, e_ch, e_coil;
      bit e_hold;
      if (!m_seq) begin
         e_ready = !oa; e_busy = 0; e_done = 0; e_err = 0;
         e_active = m_active; e_ch = m_coil; e_hold = (m_coil != 0);
      end else begin
         e_ready = 0; e_busy = 1;
         e_done = (m_k == m_kdone) && !oa;
         e_err  = e_done && m_inv;
         if (m_kind == K_SHORT) begin
            e_active = m_active; e_ch = m_coil; e_hold = (m_coil != 0);
         end else if (m_kind == K_OPEN) begin
            e_active = 0; e_ch = 0; e_hold = 0;
         end else begin
            e_active = (m_k == m_kdone) ? m_tgt : 0;
            e_ch     = (m_k > B) ? m_tgt : 0;
            e_hold   = (m_k == m_kdone);
         end
      end
      e_coil = onehot(e_ch);
`ifdef RELAY_SEQ_HOLD_PWM_EN
      if (e_hold && (hold_age % 16) >= HOLD) e_coil = 0;
`else
      if (e_hold) e_coil = onehot(e_ch);
`endif
      check("req_ready",  int'(rq.req_ready), e_ready);
      check("busy",       int'(busy),         e_busy);
      check("done",       int'(done),         e_done);
      check("err",        int'(err),          e_err);
      check("active_sel", int'(active_sel),   e_active);
      check("coil",       int'(coil),         e_coil);
      check("coil_onehot", int'($countones(coil) <= 1), 1);
   endtask

   task automatic cyc(input bit v, input int sel, input bit oa);
      rq.req_valid = v;
      rq.req_sel   = SEL_W'(sel);
      open_all     = oa;
      @(negedge clk);
      compare(oa);
      @(posedge clk);
      model_step(v, sel, oa);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0);
   endtask

   task automatic async_reset();
      rq.req_valid = 1'b0;
      rq.req_sel   = '0;
      open_all     = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare(1'b0);
      @(negedge clk);
      compare(1'b0);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      model_step(1'b0, 0, 1'b0);
      #1;
   endtask

   initial begin
      int oa_left;
      bit v, oa;
      int sel;
      model_reset();
      rq.req_valid = 1'b0;
      rq.req_sel   = '0;
      #3;
      compare(1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Channel change, then coil-to-coil switch with break gap.
      cyc(1'b1, 2, 1'b0); idle(B + S + 3);
      cyc(1'b1, 3, 1'b0); idle(B + S + 3);
      // Same-channel and out-of-range requests complete in one cycle.
      cyc(1'b1, 3, 1'b0); idle(1);
      cyc(1'b1, 5, 1'b0); idle(1);
      cyc(1'b1, 0, 1'b0); idle(B + 3);
      // Emergency open ten cycles into MAKE.
      cyc(1'b1, 1, 1'b0); idle(B + 10);
      for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b1);
      idle(3);
      // Asynchronous reset in the middle of BREAK, then a normal request.
      cyc(1'b1, 2, 1'b0); idle(5);
      async_reset();
      cyc(1'b1, 1, 1'b0); idle(B + S + 20);

      oa_left = 0;
      for (int i = 0; i < 3000; i++) begin
         v   = ($urandom_range(0, 3) == 0);
         sel = $urandom_range(0, 7);
         if (oa_left > 0) begin
            oa = 1'b1; oa_left--;
         end else begin
            oa = 1'b0;
            if ($urandom_range(0, 199) == 0) oa_left = $urandom_range(1, 4);
         end
         cyc(v, sel, oa);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
